// File: rtl/mux_rr_sequencer.sv
// Round-robin burst sequencer that drives the chip select and select lines of the 3-input mux.
// Defining MUX_SEQ_PARK_EN makes the mux park on the last-granted source while idle.
module mux_rr_sequencer #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       en,
  input  logic [2:0] req,
  output logic       cs,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       burst_done
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BURST_LEN - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       last, last_nx, base, win, sel_nx;
  logic [1:0]       c0, c1, c2;
  logic             arb, cs_nx, busy_nx, done_nx;
  logic [2:0]       gnt_nx;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // A completing burst arbitrates against its own source, not the stale last.
  always_comb begin
    base = (state == HOLD && cnt == '0) ? sel : last;
    c0   = next_idx(base);
    c1   = next_idx(c0);
    c2   = next_idx(c1);
    if (req_at(req, c0))      win = c0;
    else if (req_at(req, c1)) win = c1;
    else                      win = c2;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    sel_nx   = sel;
    arb      = 1'b0;
    case (state)
      IDLE: arb = en && (|req);
      HOLD: begin
        if (cnt == '0) begin
          last_nx = sel;
          arb     = en && (|req);
          if (!arb) state_nx = IDLE;
        end else if (!req_at(req, sel)) begin
          last_nx  = sel;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (arb) begin
      state_nx = HOLD;
      cnt_nx   = RELOAD;
      sel_nx   = win;
    end
    if (state_nx == IDLE) cnt_nx = '0;

    // Outputs are precomputed from the next state so they leave flops directly.
    if (state_nx == HOLD) begin
      cs_nx   = 1'b1;
      busy_nx = 1'b1;
      gnt_nx  = onehot(sel_nx);
      done_nx = (cnt_nx == '0);
    end else begin
      busy_nx = 1'b0;
      gnt_nx  = 3'b000;
      done_nx = 1'b0;
`ifdef MUX_SEQ_PARK_EN
      cs_nx   = 1'b1;
      sel_nx  = last_nx;
`else
      cs_nx   = 1'b0;
      sel_nx  = 2'b00;
`endif
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 2'd2;
      cs         <= 1'b0;
      sel        <= 2'b00;
      gnt        <= 3'b000;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last       <= last_nx;
      cs         <= cs_nx;
      sel        <= sel_nx;
      gnt        <= gnt_nx;
      busy       <= busy_nx;
      burst_done <= done_nx;
    end
  end

endmodule
